// File: rtl/ext_int_if.sv
// Register/handshake bundle of the external interrupt unit.
// master: register writer + core (writes, ack); slave: ext_int_ctrl.
interface ext_int_if;
  logic       mcucr_we;
  logic [3:0] mcucr_wdata;
  logic       isc2_we;
  logic       isc2_wdata;
  logic       gicr_we;
  logic [2:0] gicr_wdata;
  logic       gifr_we;
  logic [2:0] gifr_wdata;
  logic       irq_ack;
  logic [3:0] mcucr_q;
  logic       isc2_q;
  logic [2:0] gicr_q;
  logic [2:0] gifr_q;
  logic       irq_req;
  logic [1:0] irq_vector;

  modport master (
    output mcucr_we, mcucr_wdata,
    output isc2_we, isc2_wdata,
    output gicr_we, gicr_wdata,
    output gifr_we, gifr_wdata,
    output irq_ack,
    input  mcucr_q, isc2_q, gicr_q,
    input  gifr_q, irq_req, irq_vector
  );

  modport slave (
    input  mcucr_we, mcucr_wdata,
    input  isc2_we, isc2_wdata,
    input  gicr_we, gicr_wdata,
    input  gifr_we, gifr_wdata,
    input  irq_ack,
    output mcucr_q, isc2_q, gicr_q,
    output gifr_q, irq_req, irq_vector
  );
endinterface

// File: rtl/ext_int_ctrl.sv
// External interrupt unit: INT0/INT1/INT2 sense, GICR/GIFR, prioritised req/ack.
// Ports: clk, clr_n (sync active-low), pin_int {INT2,INT1,INT0}, bus (ext_int_if.slave).
// Option: EXT_INT_FILTER_EN adds a FILTER_CYCLES glitch filter in front of the sampler.
module ext_int_ctrl #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [2:0] pin_int,
  ext_int_if.slave   bus
);

  if (FILTER_CYCLES < 1) begin : g_bad_cfg
    $error("FILTER_CYCLES must be at least 1");
  end

  logic [2:0] pin_src;

`ifdef EXT_INT_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [2:0]         filt_q, filt_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d;

  // cnt counts consecutive raw samples that disagree with the
  // filtered level; any agreeing sample restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (pin_int[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILTER_CYCLES - 1))
          filt_d[i] = pin_int[i];
        else
          cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      filt_q <= 3'b111;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pin_src = filt_q;
`else
  assign pin_src = pin_int;
`endif

  logic [2:0] s_q, s_d, p_q, p_d;
  logic [3:0] mcucr_q, mcucr_d;
  logic       isc2_q, isc2_d;
  logic [2:0] gicr_q, gicr_d;
  logic [2:0] gifr_q, gifr_d;
  logic       irq_req_q, irq_req_d;
  logic [1:0] irq_vec_q, irq_vec_d;

  // Line-indexed views: [0]=INT0 [1]=INT1 [2]=INT2
  logic [2:0] en, flag, det, lvl, pend;
  logic [2:0] hw_clr, sw_clr, flag_n;
  logic [2:0] fall, rise, chg;
  logic [1:0][1:0] isc;
  logic       ack_take, cur_pend;
  logic [1:0] sel;

  assign en     = {gicr_q[0], gicr_q[2], gicr_q[1]};
  assign flag   = {gifr_q[0], gifr_q[2], gifr_q[1]};
  assign sw_clr = bus.gifr_we ?
                  {bus.gifr_wdata[0], bus.gifr_wdata[2],
                   bus.gifr_wdata[1]} : 3'b000;
  assign isc    = {mcucr_q[3:2], mcucr_q[1:0]};
  assign fall   = p_q & ~s_q;
  assign rise   = ~p_q & s_q;
  assign chg    = p_q ^ s_q;

  always_comb begin
    lvl = 3'b000;
    det = 3'b000;
    for (int i = 0; i < 2; i++) begin
      unique case (isc[i])
        2'b00: lvl[i] = 1'b1;
        2'b01: det[i] = chg[i];
        2'b10: det[i] = fall[i];
        2'b11: det[i] = rise[i];
      endcase
    end
    det[2] = isc2_q ? rise[2] : fall[2];
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      pend[i] = en[i] & (lvl[i] ? ~s_q[i] : flag[i]);
  end

  assign ack_take = bus.irq_ack & irq_req_q;

  always_comb begin
    hw_clr   = 3'b000;
    cur_pend = 1'b0;
    case (irq_vec_q)
      2'd1: begin
        hw_clr[0] = ack_take & ~lvl[0];
        cur_pend  = pend[0];
      end
      2'd2: begin
        hw_clr[1] = ack_take & ~lvl[1];
        cur_pend  = pend[1];
      end
      2'd3: begin
        hw_clr[2] = ack_take;
        cur_pend  = pend[2];
      end
      default: ;
    endcase
  end

  // A fresh detection in the clearing cycle keeps the flag set.
  assign flag_n = (flag & ~(hw_clr | sw_clr)) | det;

  always_comb begin
    sel = 2'd0;
    if (pend[0])      sel = 2'd1;
    else if (pend[1]) sel = 2'd2;
    else if (pend[2]) sel = 2'd3;
  end

  always_comb begin
    s_d     = pin_src;
    p_d     = s_q;
    mcucr_d = bus.mcucr_we ? bus.mcucr_wdata : mcucr_q;
    isc2_d  = bus.isc2_we  ? bus.isc2_wdata  : isc2_q;
    gicr_d  = bus.gicr_we  ? bus.gicr_wdata  : gicr_q;
    gifr_d  = {flag_n[1], flag_n[0], flag_n[2]};
    irq_req_d = irq_req_q;
    irq_vec_d = irq_vec_q;
    if (ack_take) begin
      // Drop for one cycle; the next cycle re-arbitrates.
      irq_req_d = 1'b0;
      irq_vec_d = 2'd0;
    end else if (!(irq_req_q && cur_pend)) begin
      // Vector stays frozen while its source still pends.
      irq_req_d = (sel != 2'd0);
      irq_vec_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      s_q       <= 3'b111;
      p_q       <= 3'b111;
      mcucr_q   <= '0;
      isc2_q    <= 1'b0;
      gicr_q    <= '0;
      gifr_q    <= '0;
      irq_req_q <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      s_q       <= s_d;
      p_q       <= p_d;
      mcucr_q   <= mcucr_d;
      isc2_q    <= isc2_d;
      gicr_q    <= gicr_d;
      gifr_q    <= gifr_d;
      irq_req_q <= irq_req_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  assign bus.mcucr_q    = mcucr_q;
  assign bus.isc2_q     = isc2_q;
  assign bus.gicr_q     = gicr_q;
  assign bus.gifr_q     = gifr_q;
  assign bus.irq_req    = irq_req_q;
  assign bus.irq_vector = irq_vec_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: settled vector table plus
// cycle-exact sequences for latency, handshake and set-vs-clear.
module tb_ext_int_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [2:0] pin_int;
  int         n_chk = 0;
  int         n_fail = 0;

  ext_int_if bus ();

  ext_int_ctrl #(.FILTER_CYCLES(4)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .pin_int(pin_int),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pin;
    logic       mw;
    logic [3:0] md;
    logic       iw;
    logic       id;
    logic       gw;
    logic [2:0] gd;
    logic       fw;
    logic [2:0] fd;
    logic       ack;
    logic [2:0] e_gifr;
    logic       e_req;
    logic [1:0] e_vec;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mcucr_we = 0; bus.isc2_we = 0; bus.gicr_we = 0;
    bus.gifr_we = 0; bus.irq_ack = 0;
  endtask

  task automatic chk_out(input string nm, input logic [2:0] g,
                         input logic r, input logic [1:0] v);
    chk({nm, " gifr"}, 8'(bus.gifr_q), 8'(g));
    chk({nm, " req"}, 8'(bus.irq_req), 8'(r));
    chk({nm, " vec"}, 8'(bus.irq_vector), 8'(v));
  endtask

  initial begin
    // pin  mw md     iw id  gw gd     fw fd     ack  gifr   req vec
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b111,1,4'b0010,0,0,1,3'b010,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b110,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b010,1,1});
    tv.push_back('{3'b110,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,1,3'b011,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b010,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b011,1,1});
    tv.push_back('{3'b010,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b001,1,3});
    tv.push_back('{3'b010,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,1,3'b100,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b101,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b000,1,2});
    tv.push_back('{3'b101,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b000,1,2});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,1,1,1,3'b000,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b011,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b001,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,1,3'b001,0,3'b000,0,0});
    tv.push_back('{3'b111,1,4'b0110,0,0,1,3'b100,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b101,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b100,1,2});
    tv.push_back('{3'b101,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b100,1,2});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b000,0,0});
    tv.push_back('{3'b111,1,4'b1110,0,0,0,3'b000,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b101,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b100,1,2});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b000,0,0});
    tv.push_back('{3'b111,1,4'b1010,0,0,1,3'b110,0,3'b000,0,3'b000,0,0});
    tv.push_back('{3'b100,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b110,1,1});
    tv.push_back('{3'b100,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b100,1,2});
    tv.push_back('{3'b100,0,4'b0000,0,0,0,3'b000,0,3'b000,1,3'b000,0,0});
    tv.push_back('{3'b111,0,4'b0000,0,0,0,3'b000,0,3'b000,0,3'b000,0,0});

    idle();
    bus.mcucr_wdata = 0; bus.isc2_wdata = 0;
    bus.gicr_wdata = 0; bus.gifr_wdata = 0;
    pin_int = 3'b111;
    clr_n = 1'b0;
    step(3);
    clr_n = 1'b1;
    step(1);
    chk_out("reset", 3'b000, 0, 2'd0);
    chk("reset mcucr", 8'(bus.mcucr_q), 8'h0);
    chk("reset gicr", 8'(bus.gicr_q), 8'h0);
    chk("reset isc2", 8'(bus.isc2_q), 8'h0);

    for (int i = 0; i < tv.size(); i++) begin
      pin_int = tv[i].pin;
      bus.mcucr_we = tv[i].mw; bus.mcucr_wdata = tv[i].md;
      bus.isc2_we  = tv[i].iw; bus.isc2_wdata  = tv[i].id;
      bus.gicr_we  = tv[i].gw; bus.gicr_wdata  = tv[i].gd;
      bus.gifr_we  = tv[i].fw; bus.gifr_wdata  = tv[i].fd;
      bus.irq_ack  = tv[i].ack;
      step(1);
      idle();
      step((i == 0) ? 19 : 11);
      chk_out($sformatf("v%0d", i), tv[i].e_gifr,
              tv[i].e_req, tv[i].e_vec);
    end
    chk("rb mcucr", 8'(bus.mcucr_q), 8'b1010);
    chk("rb gicr", 8'(bus.gicr_q), 8'b110);
    chk("rb isc2", 8'(bus.isc2_q), 8'h1);

`ifdef EXT_INT_FILTER_EN
    bus.gicr_we = 1; bus.gicr_wdata = 3'b010;
    step(1); idle();
    pin_int = 3'b110; step(2);
    pin_int = 3'b111; step(12);
    chk_out("glitch", 3'b000, 0, 2'd0);
    pin_int = 3'b110; step(6);
    pin_int = 3'b111; step(12);
    chk("pulse gifr", 8'(bus.gifr_q), 8'b010);
`else
    // exact latency: INT0 falling, enabled
    bus.gicr_we = 1; bus.gicr_wdata = 3'b010;
    step(1); idle(); step(2);
    pin_int = 3'b110; step(1);
    chk_out("lat s", 3'b000, 0, 2'd0);
    step(1);
    chk_out("lat flag", 3'b010, 0, 2'd0);
    step(1);
    chk_out("lat req", 3'b010, 1, 2'd1);
    bus.irq_ack = 1; step(1); idle();
    chk_out("lat ack", 3'b000, 0, 2'd0);
    pin_int = 3'b111; step(3);

    // back-to-back vectors: drop cycle then next vector
    bus.gicr_we = 1; bus.gicr_wdata = 3'b110;
    step(1); idle();
    pin_int = 3'b100; step(4);
    chk_out("b2b first", 3'b110, 1, 2'd1);
    bus.irq_ack = 1; step(1); idle();
    chk_out("b2b drop", 3'b100, 0, 2'd0);
    step(1);
    chk_out("b2b next", 3'b100, 1, 2'd2);
    bus.irq_ack = 1; step(1); idle();
    step(2);
    chk_out("b2b done", 3'b000, 0, 2'd0);

    // level INT1: ack drops one cycle, then reasserts
    bus.mcucr_we = 1; bus.mcucr_wdata = 4'b0010;
    bus.gicr_we = 1; bus.gicr_wdata = 3'b100;
    step(1); idle(); step(2);
    chk_out("lvl req", 3'b000, 1, 2'd2);
    bus.irq_ack = 1; step(1); idle();
    chk_out("lvl drop", 3'b000, 0, 2'd0);
    step(1);
    chk_out("lvl again", 3'b000, 1, 2'd2);
    pin_int = 3'b111; step(2);
    chk_out("lvl rel", 3'b000, 0, 2'd0);

    // INT2 rising, disabled: set wins over clear
    bus.isc2_we = 1; bus.isc2_wdata = 1;
    bus.gicr_we = 1; bus.gicr_wdata = 3'b000;
    pin_int = 3'b011;
    step(1); idle(); step(2);
    pin_int = 3'b111; step(1);
    bus.gifr_we = 1; bus.gifr_wdata = 3'b001;
    step(1); idle();
    chk_out("set wins", 3'b001, 0, 2'd0);
    bus.irq_ack = 1; step(1); idle();
    chk_out("stray ack", 3'b001, 0, 2'd0);
    bus.gifr_we = 1; bus.gifr_wdata = 3'b001;
    step(1); idle();
    chk("w1c", 8'(bus.gifr_q), 8'h0);

    // INT0 any change: new edge in ack cycle keeps flag
    bus.mcucr_we = 1; bus.mcucr_wdata = 4'b0001;
    bus.gicr_we = 1; bus.gicr_wdata = 3'b010;
    step(1); idle(); step(2);
    pin_int = 3'b110; step(3);
    chk_out("chg req", 3'b010, 1, 2'd1);
    pin_int = 3'b111; step(1);
    bus.irq_ack = 1; step(1); idle();
    chk_out("ack+edge", 3'b010, 0, 2'd0);
    step(1);
    chk_out("ack+edge req", 3'b010, 1, 2'd1);
    bus.irq_ack = 1; step(1); idle();
    chk_out("chg done", 3'b000, 0, 2'd0);
`endif

    // reset in the middle of a pending request
    bus.mcucr_we = 1; bus.mcucr_wdata = 4'b0001;
    bus.gicr_we = 1; bus.gicr_wdata = 3'b010;
    step(1); idle();
    pin_int = 3'b110; step(12);
    chk("pre rst req", 8'(bus.irq_req), 8'h1);
    clr_n = 1'b0; step(1); clr_n = 1'b1;
    chk_out("mid rst", 3'b000, 0, 2'd0);
    chk("mid rst gicr", 8'(bus.gicr_q), 8'h0);
    chk("mid rst mcucr", 8'(bus.mcucr_q), 8'h0);
    step(8);
    chk_out("post rst", 3'b000, 0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
